// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream join family: skid occupancy state,
// log2 and lane-offset helpers.
package stream_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_e;

  localparam int SKID_DEPTH = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bit offset of lane ch on a bus packed with lane 0 in the LSBs.
  function automatic int lane_lsb(input int ch, input int wd);
    return ch * wd;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Generic 2-entry register slice: full throughput, registered outputs, and an
// in_ready that depends only on local state (never on out_ready).
//
// state      | meaning
// SKID_EMPTY | nothing held, out_valid low
// SKID_ONE   | main register holds the output beat
// SKID_FULL  | main and skid both hold beats, in_ready low
module stream_skid_buf
  import stream_pkg::*;
#(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_data
);

  skid_state_e state, state_nxt;
  logic [WD-1:0] main_q, skid_q;
  logic in_fire, out_fire;
  logic load_main, load_skid, main_from_skid;

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_nxt = SKID_ONE;
        end
      end
      SKID_ONE: begin
        // A draining main register takes the new beat directly.
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = SKID_FULL;
        end else if (out_fire) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_nxt      = SKID_ONE;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SKID_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) main_q <= in_data;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/stream_join_n.sv
// N-way stream join: consumes one beat from every channel in the same cycle and
// emits their concatenation, with last-alignment checking and a packet counter.
module stream_join_n
  import stream_pkg::*;
#(
  parameter int DATA_WD  = 4,
  parameter int CH_NUM   = 2,
  parameter int HAS_LAST = 1,
  parameter int LAST_CH  = 0,
  parameter int OUT_REG  = 1,
  parameter int CNT_WD   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CH_NUM-1:0]         in_valid,
  input  logic [CH_NUM-1:0]         in_last,
  input  logic [CH_NUM*DATA_WD-1:0] in_data,
  output logic [CH_NUM-1:0]         in_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [CH_NUM*DATA_WD-1:0] out_data,
  input  logic                      out_ready,
  output logic                      err_last,
  output logic [CNT_WD-1:0]         pkt_cnt
);

  localparam int BUS_WD = CH_NUM * DATA_WD;

  logic all_v, accept, join_fire;
  logic last_sel, beat_last, lane_mismatch;

  assign all_v     = &in_valid;
  assign join_fire = all_v && accept;
  assign in_ready  = {CH_NUM{join_fire}};
  assign last_sel  = (HAS_LAST != 0) ? in_last[LAST_CH] : 1'b0;
  assign lane_mismatch = (|in_last) && !(&in_last);

  generate
    if (OUT_REG != 0) begin : g_reg
      logic              buf_ready;
      logic [BUS_WD:0]   buf_out;

      stream_skid_buf #(.WD(BUS_WD + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (all_v && !rst),
        .in_ready  (buf_ready),
        .in_data   ({last_sel, in_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
      );

      assign accept    = buf_ready && !rst;
      assign out_data  = buf_out[BUS_WD-1:0];
      assign beat_last = buf_out[BUS_WD];
    end else begin : g_comb
      assign accept    = out_ready && !rst;
      assign out_valid = all_v;
      assign out_data  = in_data;
      assign beat_last = last_sel;
    end
  endgenerate

  generate
    if (HAS_LAST != 0) begin : g_last
      logic              err_q;
      logic [CNT_WD-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          err_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          if (join_fire && lane_mismatch) err_q <= 1'b1;
          // Wraps silently at the counter width.
          if (out_valid && out_ready && beat_last) cnt_q <= cnt_q + CNT_WD'(1);
        end
      end

      assign out_last = beat_last;
      assign err_last = err_q;
      assign pkt_cnt  = cnt_q;
    end else begin : g_no_last
      assign out_last = 1'b0;
      assign err_last = 1'b0;
      assign pkt_cnt  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_stream_join_n.sv
// Bench for stream_join_n: table vectors on a pass-through instance, directed
// and randomized sequences on a 3-lane registered instance.
module tb_stream_join_n;
  import stream_pkg::*;

  localparam int DW = 4;
  localparam int CH = 3;
  localparam int WD = CH * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [CH-1:0] in_valid, in_last, in_ready;
  logic [WD-1:0] in_data, out_data;
  logic          out_valid, out_last, out_ready, err_last;
  logic [1:0]    pkt_cnt;

  logic [1:0] b_in_valid, b_in_last, b_in_ready;
  logic [7:0] b_in_data, b_out_data;
  logic       b_out_valid, b_out_last, b_out_ready, b_err_last;
  logic [3:0] b_pkt_cnt;

  stream_join_n #(.DATA_WD(DW), .CH_NUM(CH), .HAS_LAST(1), .LAST_CH(1),
                  .OUT_REG(1), .CNT_WD(2)) dut_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .err_last(err_last), .pkt_cnt(pkt_cnt)
  );

  stream_join_n #(.DATA_WD(4), .CH_NUM(2), .HAS_LAST(1), .LAST_CH(0),
                  .OUT_REG(0), .CNT_WD(4)) dut_comb (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_data(b_out_data), .out_ready(b_out_ready),
    .err_last(b_err_last), .pkt_cnt(b_pkt_cnt)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d;
    logic       r;
    logic [1:0] ir;
    logic       ov;
    logic       ol;
    logic [7:0] od;
    logic       err;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[11];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WD-1:0] rep3(input logic [3:0] n);
    return {n, n, n};
  endfunction

  function automatic logic [WD-1:0] rnd_data(input int k);
    logic [WD-1:0] d;
    d = '0;
    for (int c = 0; c < CH; c++) d[lane_lsb(c, DW) +: DW] = 4'(k * (c + 1) + c * 5);
    return d;
  endfunction

  initial begin
    int seq, out_n, cyc, nlast;
    logic [CH-1:0] pv;
    logic stall, jf, of;
    logic [WD-1:0] prev_d;
    logic [1:0] cnt_exp[5];

    tbl[0]  = '{2'b00, 2'b00, 8'h21, 1'b1, 2'b00, 1'b0, 1'b0, 8'h21, 1'b0, 4'd0};
    tbl[1]  = '{2'b01, 2'b01, 8'h43, 1'b1, 2'b00, 1'b0, 1'b1, 8'h43, 1'b0, 4'd0};
    tbl[2]  = '{2'b10, 2'b00, 8'h65, 1'b1, 2'b00, 1'b0, 1'b0, 8'h65, 1'b0, 4'd0};
    tbl[3]  = '{2'b11, 2'b00, 8'h87, 1'b0, 2'b00, 1'b1, 1'b0, 8'h87, 1'b0, 4'd0};
    tbl[4]  = '{2'b11, 2'b11, 8'ha9, 1'b1, 2'b11, 1'b1, 1'b1, 8'ha9, 1'b0, 4'd0};
    tbl[5]  = '{2'b11, 2'b01, 8'hcb, 1'b0, 2'b00, 1'b1, 1'b1, 8'hcb, 1'b0, 4'd1};
    tbl[6]  = '{2'b11, 2'b10, 8'hed, 1'b1, 2'b11, 1'b1, 1'b0, 8'hed, 1'b0, 4'd1};
    tbl[7]  = '{2'b00, 2'b00, 8'h0f, 1'b1, 2'b00, 1'b0, 1'b0, 8'h0f, 1'b1, 4'd1};
    tbl[8]  = '{2'b11, 2'b01, 8'h12, 1'b1, 2'b11, 1'b1, 1'b1, 8'h12, 1'b1, 4'd1};
    tbl[9]  = '{2'b11, 2'b11, 8'h34, 1'b1, 2'b11, 1'b1, 1'b1, 8'h34, 1'b1, 4'd2};
    tbl[10] = '{2'b01, 2'b00, 8'h56, 1'b0, 2'b00, 1'b0, 1'b0, 8'h56, 1'b1, 4'd3};
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) step();

    // Reset state, and in_ready forced low while rst is high even with all valids.
    in_valid = 3'b111;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err_last", 32'(err_last), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    in_valid = '0;
    rst = 1'b0;
    step();

    // Pass-through instance: table vectors.
    for (int i = 0; i < 11; i++) begin
      b_in_valid = tbl[i].v; b_in_last = tbl[i].l;
      b_in_data = tbl[i].d; b_out_ready = tbl[i].r;
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", i), 32'(b_in_ready), 32'(tbl[i].ir));
      check($sformatf("tbl%0d_out_valid", i), 32'(b_out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_out_last", i), 32'(b_out_last), 32'(tbl[i].ol));
      check($sformatf("tbl%0d_out_data", i), 32'(b_out_data), 32'(tbl[i].od));
      check($sformatf("tbl%0d_err_last", i), 32'(b_err_last), 32'(tbl[i].err));
      check($sformatf("tbl%0d_pkt_cnt", i), 32'(b_pkt_cnt), 32'(tbl[i].cnt));
      step();
    end
    b_in_valid = '0;

    // Back-to-back stream, one beat per cycle, one cycle latency.
    in_valid = 3'b111; in_last = '0; out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      in_data = rep3(4'(n));
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'h7);
      if (n > 0) begin
        check("stream_out_valid", 32'(out_valid), 32'd1);
        check("stream_out_data", 32'(out_data), 32'(rep3(4'(n - 1))));
      end
      step();
    end
    in_valid = '0;
    @(negedge clk);
    check("stream_tail_valid", 32'(out_valid), 32'd1);
    check("stream_tail_data", 32'(out_data), 32'(rep3(4'hf)));
    step();
    @(negedge clk);
    check("stream_drained", 32'(out_valid), 32'd0);
    check("stream_pkt_cnt", 32'(pkt_cnt), 32'd0);
    step();

    // Partial valid set waits; channel 0 holds its beat.
    in_valid = 3'b001; in_data = {4'h3, 4'h2, 4'ha};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("partial_in_ready", 32'(in_ready), 32'd0);
      check("partial_out_valid", 32'(out_valid), 32'd0);
      step();
      in_data[WD-1:DW] = {4'(c + 9), 4'(c)};
    end
    in_valid = 3'b111; in_data = {4'h6, 4'h5, 4'ha};
    @(negedge clk);
    check("partial_join_ready", 32'(in_ready), 32'h7);
    step();
    in_valid = '0;
    @(negedge clk);
    check("partial_out_valid1", 32'(out_valid), 32'd1);
    check("partial_out_data", 32'(out_data), 32'h65a);
    step();
    @(negedge clk);
    check("partial_single_beat", 32'(out_valid), 32'd0);
    step();

    // Last mismatch on beat 5, LAST_CH=1 sees last=1.
    in_valid = 3'b111;
    for (int b = 0; b < 6; b++) begin
      in_data = rep3(4'(b + 1));
      in_last = (b == 5) ? 3'b011 : 3'b000;
      @(negedge clk);
      check("mm_err_before", 32'(err_last), 32'd0);
      step();
    end
    in_valid = '0; in_last = '0;
    @(negedge clk);
    check("mm_err_set", 32'(err_last), 32'd1);
    check("mm_out_valid", 32'(out_valid), 32'd1);
    check("mm_out_last", 32'(out_last), 32'd1);
    check("mm_out_data", 32'(out_data), 32'(rep3(4'h6)));
    check("mm_cnt_before", 32'(pkt_cnt), 32'd0);
    step();
    @(negedge clk);
    check("mm_cnt_after", 32'(pkt_cnt), 32'd1);
    step();
    repeat (3) step();
    @(negedge clk);
    check("mm_err_sticky", 32'(err_last), 32'd1);
    step();

    // 2-bit packet counter wraps: 1,2,3,0,1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("cnt_rst_err", 32'(err_last), 32'd0);
    check("cnt_rst_cnt", 32'(pkt_cnt), 32'd0);
    step();
    for (int p = 0; p < 5; p++) begin
      in_valid = 3'b111; in_last = 3'b000; in_data = rep3(4'(p));
      step();
      in_last = 3'b111; in_data = rep3(4'(p + 8));
      step();
      in_valid = '0; in_last = '0;
      step();
      @(negedge clk);
      check($sformatf("cnt_pkt%0d", p), 32'(pkt_cnt), 32'(cnt_exp[p]));
      step();
    end

    // Fill main and skid with out_ready low, then reset mid-stream.
    out_ready = 1'b0; in_valid = 3'b111; in_last = 3'b010; in_data = rep3(4'hc);
    @(negedge clk);
    check("skid_ready0", 32'(in_ready), 32'h7);
    step();
    in_last = 3'b000; in_data = rep3(4'hd);
    @(negedge clk);
    check("skid_ready1", 32'(in_ready), 32'h7);
    step();
    in_data = rep3(4'he);
    @(negedge clk);
    check("skid_full_ready", 32'(in_ready), 32'd0);
    check("skid_out_valid", 32'(out_valid), 32'd1);
    check("skid_out_data", 32'(out_data), 32'(rep3(4'hc)));
    check("skid_out_last", 32'(out_last), 32'd1);
    check("skid_err", 32'(err_last), 32'd1);
    step();
    @(negedge clk);
    check("skid_stable_data", 32'(out_data), 32'(rep3(4'hc)));
    check("skid_stable_ready", 32'(in_ready), 32'd0);
    check("skid_cnt", 32'(pkt_cnt), 32'd1);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("midrst_err", 32'(err_last), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1; in_last = '0; in_data = rep3(4'h7);
    @(negedge clk);
    check("resume_ready", 32'(in_ready), 32'h7);
    step();
    in_valid = '0;
    @(negedge clk);
    check("resume_valid", 32'(out_valid), 32'd1);
    check("resume_data", 32'(out_data), 32'(rep3(4'h7)));
    step();
    @(negedge clk);
    check("resume_no_stale", 32'(out_valid), 32'd0);
    step();

    // Random valids and backpressure against an in-order scoreboard.
    rst = 1'b1;
    step();
    rst = 1'b0;
    seq = 0; out_n = 0; cyc = 0; nlast = 0; pv = '0; stall = 1'b0; prev_d = '0;
    while (out_n < 2000 && cyc < 20000) begin
      in_valid  = pv;
      in_data   = rnd_data(seq);
      in_last   = (seq % 3 == 2) ? 3'b111 : 3'b000;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      jf = (&in_valid) && (in_ready == 3'b111);
      of = out_valid && out_ready;
      if (stall) begin
        check("rnd_stall_valid", 32'(out_valid), 32'd1);
        check("rnd_stall_data", 32'(out_data), 32'(prev_d));
      end
      if (of) begin
        check("rnd_data", 32'(out_data), 32'(rnd_data(out_n)));
        check("rnd_last", 32'(out_last), 32'(out_n % 3 == 2));
        if (out_last) nlast++;
        out_n++;
      end
      stall  = out_valid && !out_ready;
      prev_d = out_data;
      step();
      cyc++;
      if (jf) begin
        seq++;
        pv = '0;
      end
      for (int c = 0; c < CH; c++) begin
        if (!pv[c] && seq < 2000) pv[c] = 1'($urandom_range(0, 1));
      end
    end
    in_valid = '0;
    check("rnd_beat_count", 32'(out_n), 32'd2000);
    check("rnd_pkt_cnt", 32'(pkt_cnt), 32'(nlast % 4));
    check("rnd_err_clear", 32'(err_last), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
